// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared constants and types for the instruction fetch queue.
// This package is the single source for the default depth, the default reset PC,
// the queue entry layout and the FSM state encodings.
package ifetch_queue_pkg;

   localparam int          DEFAULT_DEPTH    = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          ENTRY_W          = 64;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } ifq_state_t;

   // One queue entry: the fetch PC plus the instruction word read at that PC.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO with push, pop and flush.
// DEPTH must be a power of two, so the pointers wrap on their own.
// Flush empties the FIFO in one cycle and takes priority over push and pop.
module ifq_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int W     = ENTRY_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Storage write; the array has no reset because count gates what is visible.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit that issues one synchronous ROM read
// per cycle and buffers the returned {pc, instr} pairs for decode.
// Optional feature macro: IFQ_BYPASS_EN. When defined, a response that arrives
// while the queue is empty is shown on the output in the same cycle.
//
// Output handshake: one transfer happens on every rising edge where out_valid
// and out_ready are both high. out_valid never depends on out_ready, and while
// out_valid is high out_pc/out_instr hold steady until the transfer or a flush.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   output logic [9:0]             imem_addr,
   input  logic [31:0]            imem_q,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [31:0]            out_pc,
   output ifq_state_t             dbg_state,
   output logic [$clog2(DEPTH):0] dbg_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 1;
   localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);

   ifq_state_t    state;
   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic [CW-1:0] count;
   logic          fifo_full;
   logic          fifo_empty;
   ifq_entry_t    head;
   ifq_entry_t    resp;
   logic          credit;
   logic          push;
   logic          pop;
   logic          bypass_take;
   logic [OW-1:0] occupancy;
   logic [OW-1:0] occ_next;
   logic          unused_ok;

   // The read address follows fetch_pc directly, so a read goes out every cycle.
   assign imem_addr = fetch_pc[11:2];
   assign resp      = '{pc: inflight_pc, instr: imem_q};

   // A read earns a queue slot only if the slots already owed (queued plus
   // pending) leave room; uncredited reads are simply ignored on return.
   assign occupancy = {1'b0, count} + OW'(inflight);
   assign credit    = (state != ST_BOOT) && (occupancy < DEPTH_V);

`ifdef IFQ_BYPASS_EN
   assign bypass_take = inflight && fifo_empty && out_ready;
`else
   assign bypass_take = 1'b0;
`endif

   assign push = inflight && !bypass_take && !redirect;
   assign pop  = out_ready && !fifo_empty;

   assign dbg_state = state;
   assign dbg_count = count;
   assign unused_ok = ^{redirect_pc[1:0], fifo_full};

   ifq_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect),
      .push      (push),
      .push_data (resp),
      .pop       (pop),
      .pop_data  (head),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Slots owed after this edge, used to decide when the fetcher must stall.
   always_comb begin
      occ_next = {1'b0, count} + OW'(push) + OW'(credit) - OW'(pop);
   end

   // Output select: queue head first, otherwise the live response when bypassing.
   always_comb begin
      out_valid = 1'b0;
      out_pc    = '0;
      out_instr = '0;
      if (!fifo_empty) begin
         out_valid = 1'b1;
         out_pc    = head.pc;
         out_instr = head.instr;
      end
`ifdef IFQ_BYPASS_EN
      else if (inflight) begin
         out_valid = 1'b1;
         out_pc    = inflight_pc;
         out_instr = imem_q;
      end
`endif
   end

   // Fetch control FSM: PC advance, pending-read tracking and BOOT/RUN/HOLD.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_BOOT;
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         state    <= ST_RUN;
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
      end else begin
         inflight <= credit;
         if (credit) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         unique case (state)
            ST_BOOT: state <= ST_RUN;
            ST_RUN:  if (occ_next == DEPTH_V) state <= ST_HOLD;
            ST_HOLD: if (pop) state <= ST_RUN;
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: self-checking bench for ifetch_queue with a synchronous ROM.
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_ifetch_queue;
   import ifetch_queue_pkg::*;

   localparam int          DEPTH     = 4;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          MAX_STALL = 4;
`ifdef IFQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clock       = 1'b0;
   logic        reset       = 1'b1;
   logic        redirect    = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready   = 1'b0;
   logic [31:0] imem_q      = '0;
   logic [9:0]  imem_addr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   ifq_state_t  dbg_state;
   logic [2:0]  dbg_count;

   logic [31:0] rom [0:1023];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [9:0]  exp_addr;
      ifq_state_t  exp_state;
   } vec_t;
   vec_t vecs[8];

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock       (clock),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_q      (imem_q),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .dbg_state   (dbg_state),
      .dbg_count   (dbg_count)
   );

   // clock / reset block and ROM model
   always #5 clock = ~clock;

   always @(posedge clock) imem_q <= rom[imem_addr];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   // driver and checking tasks
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      redirect  = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_addr", imem_addr, RESET_PC[11:2]);
      check("rst_state", dbg_state, ST_BOOT);
      check("rst_count", dbg_count, 0);
      check("rst_pc", out_pc, 0);
      check("rst_instr", out_instr, 0);
      reset = 1'b0;
   endtask

   // Consume n consecutive instructions starting at start, one per cycle.
   task automatic expect_stream(input logic [31:0] start, input int n, input string tag);
      logic [31:0] e;
      int w;
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
      out_ready = 1'b1;
      w = 0;
      while (!out_valid && w < 10) begin
         tick();
         w++;
      end
      check({tag, "_arrive"}, out_valid, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_pc"}, out_pc, e);
         check({tag, "_instr"}, out_instr, rom[e[11:2]]);
         tick();
      end
   endtask

   task automatic wait_count(input logic [2:0] target, input string tag);
      int w;
      w = 0;
      while (dbg_count != target && w < 20) begin
         tick();
         w++;
      end
      check({tag, "_count"}, dbg_count, target);
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic        prev_flush;
      int          stall;

      for (int i = 0; i < 1024; i++) rom[i] = $urandom;
      rom[0] = 32'hAAAA_0001;
      rom[1] = 32'hBBBB_0002;
      rom[2] = 32'hCCCC_0003;
      rom[3] = 32'hDDDD_0004;

      // table: startup latency and first four instructions
      for (int k = 0; k < 8; k++) begin
         vecs[k].ready     = 1'b1;
         vecs[k].exp_valid = (k >= LAT + 1);
         vecs[k].exp_pc    = (k >= LAT + 1) ? 32'(4 * (k - LAT - 1)) : 32'h0;
         vecs[k].exp_addr  = (k < 2) ? 10'd0 : 10'(k - 1);
         vecs[k].exp_state = (k == 0) ? ST_BOOT : ST_RUN;
      end
      do_reset();
      for (int k = 0; k < 8; k++) begin
         out_ready = vecs[k].ready;
         check("tbl_valid", out_valid, vecs[k].exp_valid);
         check("tbl_addr", imem_addr, vecs[k].exp_addr);
         check("tbl_state", dbg_state, vecs[k].exp_state);
         if (vecs[k].exp_valid) begin
            check("tbl_pc", out_pc, vecs[k].exp_pc);
            check("tbl_instr", out_instr, rom[vecs[k].exp_pc[11:2]]);
         end
         tick();
      end

      // backpressure: queue fills to DEPTH and fetch stops
      do_reset();
      repeat (10) tick();
      check("bp_count", dbg_count, DEPTH);
      check("bp_valid", out_valid, 1);
      check("bp_pc", out_pc, 0);
      check("bp_addr", imem_addr, 10'd4);
      check("bp_state", dbg_state, ST_HOLD);
      expect_stream(32'h0, 5, "bp");

      // redirect with 3 queued entries and a pending read
      do_reset();
      wait_count(3'd3, "rd3");
      redirect = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      check("rd3_bubble", out_valid, 0);
      check("rd3_flushed", dbg_count, 0);
      expect_stream(32'h40, 4, "rd3");

      // redirect and pop together on a full queue; low PC bits ignored
      do_reset();
      repeat (10) tick();
      check("rdf_full", dbg_count, DEPTH);
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0123;
      tick();
      redirect = 1'b0;
      check("rdf_count", dbg_count, 0);
      check("rdf_bubble", out_valid, 0);
      expect_stream(32'h120, 2, "rdf");

      // reset mid-operation dominates a simultaneous redirect
      do_reset();
      wait_count(3'd2, "mrst");
      reset = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      reset = 1'b0;
      redirect = 1'b0;
      check("mrst_valid", out_valid, 0);
      check("mrst_addr", imem_addr, RESET_PC[11:2]);
      check("mrst_state", dbg_state, ST_BOOT);
      check("mrst_count", dbg_count, 0);
      expect_stream(RESET_PC, 2, "mrst");

      // address wrap at the top of the 1024-word ROM
      redirect = 1'b1;
      redirect_pc = 32'h0000_0FFE;
      out_ready = 1'b1;
      tick();
      redirect = 1'b0;
      check("wrap_addr0", imem_addr, 10'h3FF);
      tick();
      check("wrap_addr1", imem_addr, 10'h000);
      expect_stream(32'h0000_0FFC, 2, "wrap");

      // randomized traffic against the stream model
      do_reset();
      exp_pc = RESET_PC;
      prev_flush = 1'b1;
      stall = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset       = ($urandom_range(0, 199) == 0);
         redirect    = ($urandom_range(0, 29) == 0);
         redirect_pc = $urandom;
         out_ready   = ($urandom_range(0, 9) < 7);

         check("rnd_count_bound", dbg_count > 3'(DEPTH), 0);
         if (prev_flush) begin
            check("rnd_flush_bubble", out_valid, 0);
            stall = 0;
         end
         if (out_valid) begin
            stall = 0;
         end else begin
            stall++;
            check("rnd_idle_pc", out_pc, 0);
            check("rnd_idle_instr", out_instr, 0);
         end
         check("rnd_stall_bound", stall > MAX_STALL, 0);
         if (out_valid && out_ready && !reset) begin
            check("rnd_pc", out_pc, exp_pc);
            check("rnd_instr", out_instr, rom[exp_pc[11:2]]);
            exp_pc = exp_pc + 32'd4;
         end
         if (reset) exp_pc = RESET_PC;
         else if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
         prev_flush = reset || redirect;
         tick();
      end
      reset = 1'b0;
      redirect = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
